cache_axi_arbiter: RTL and testbench

- Shares the single cache-side read and write channel pair of the AXI bridge between the instruction cache and the data cache.
- Read side: round-robin arbitration between the two caches, one read transaction in flight, burst ownership held until the last beat returns.
- Write side: dcache only, one write in flight, tracked until the bridge reports completion.
- Blocks any read whose line address matches the in-flight write (read-after-write hazard).

---
 rtl/cache_axi_arbiter_pkg.sv | 27 ++
 rtl/cache_axi_arbiter_rr.sv | 37 +++
 rtl/cache_axi_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// rtl/cache_axi_arbiter_pkg.sv - shared types for the cache/AXI-bridge arbiter
// Purpose: access-type encodings, requester ids and one-hot FSM state encodings
// shared by cache_axi_arbiter and rr_arbiter2.
// Ports: none (package).
package cache_axi_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'b01,
    R_WAIT = 2'b10
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b01,
    W_BUSY = 2'b10
  } wr_state_e;

endpackage

// File: rtl/cache_axi_arbiter_rr.sv
// rtl/cache_axi_arbiter_rr.sv - two-input round-robin grant
// Purpose: picks one of two requesters, alternating on ties.
// Ports: clk, resetn (async active-low), req[1:0] (index = req_id_e),
//        update_en (commit current grant as last grant), grant_valid, grant_id.
module rr_arbiter2
  import cache_axi_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic       grant_valid,
  output req_id_e    grant_id
);

  req_id_e last_grant_q, last_grant_d;

  always_comb begin
    grant_valid = |req;
    if (req[REQ_IC] && req[REQ_DC]) begin
      // Tie: favour whoever was not served last.
      grant_id = (last_grant_q == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (req[REQ_IC]) begin
      grant_id = REQ_IC;
    end else begin
      grant_id = REQ_DC;
    end
    last_grant_d = (update_en && grant_valid) ? grant_id : last_grant_q;
  end

  // Reset to DC so that the icache wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_grant_q <= REQ_DC;
    else         last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/cache_axi_arbiter.sv
// rtl/cache_axi_arbiter.sv - icache/dcache arbiter for the AXI bridge channels
// Purpose: round-robin read arbitration with burst ownership, single outstanding
// dcache write, and read-after-write line hazard blocking.
// Ports: ic_rd_*/ic_ret_* icache read side; dc_rd_*/dc_ret_* dcache read side;
//        dc_wr_* dcache write side; rd_*/ret_* and wr_*/wr_done bridge side.
module cache_axi_arbiter
  import cache_axi_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LINE_OFF = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ic_rd_req,
  input  logic [2:0]            ic_rd_type,
  input  logic [ADDR_W-1:0]     ic_rd_addr,
  output logic                  ic_rd_rdy,
  output logic                  ic_ret_valid,
  output logic                  ic_ret_last,
  output logic [DATA_W-1:0]     ic_ret_data,
  input  logic                  dc_rd_req,
  input  logic [2:0]            dc_rd_type,
  input  logic [ADDR_W-1:0]     dc_rd_addr,
  output logic                  dc_rd_rdy,
  output logic                  dc_ret_valid,
  output logic                  dc_ret_last,
  output logic [DATA_W-1:0]     dc_ret_data,
  input  logic                  dc_wr_req,
  input  logic [2:0]            dc_wr_type,
  input  logic [ADDR_W-1:0]     dc_wr_addr,
  input  logic [DATA_W/8-1:0]   dc_wr_wstrb,
  input  logic [4*DATA_W-1:0]   dc_wr_data,
  output logic                  dc_wr_rdy,
  output logic                  rd_req,
  output logic [2:0]            rd_type,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_rdy,
  input  logic                  ret_valid,
  input  logic                  ret_last,
  input  logic [DATA_W-1:0]     ret_data,
  output logic                  wr_req,
  output logic [2:0]            wr_type,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W/8-1:0]   wr_wstrb,
  output logic [4*DATA_W-1:0]   wr_data,
  input  logic                  wr_rdy,
  input  logic                  wr_done
);

  localparam int LINE_W = ADDR_W - LINE_OFF;

  rd_state_e         r_state_q, r_state_d;
  wr_state_e         w_state_q, w_state_d;
  req_id_e           owner_q, owner_d;
  logic [LINE_W-1:0] wr_line_q, wr_line_d;

  logic       write_pending;
  logic       ic_haz, dc_haz;
  logic [1:0] elig;
  logic       grant_valid;
  req_id_e    grant_id;
  logic       rd_accept;

  // The hazard drops in the wr_done cycle so a blocked read can go out then.
  assign write_pending = (w_state_q == W_BUSY) && !wr_done;
  assign ic_haz = write_pending && (ic_rd_addr[ADDR_W-1:LINE_OFF] == wr_line_q);
  assign dc_haz = write_pending && (dc_rd_addr[ADDR_W-1:LINE_OFF] == wr_line_q);

  always_comb begin
    elig = 2'b00;
    if (r_state_q == R_IDLE) begin
      elig[REQ_IC] = ic_rd_req && !ic_haz;
      elig[REQ_DC] = dc_rd_req && !dc_haz;
    end
  end

  rr_arbiter2 u_rr (
    .clk         (clk),
    .resetn      (resetn),
    .req         (elig),
    .update_en   (rd_accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign rd_accept = grant_valid && rd_rdy;

  always_comb begin
    r_state_d    = r_state_q;
    owner_d      = owner_q;
    w_state_d    = w_state_q;
    wr_line_d    = wr_line_q;
    rd_req       = 1'b0;
    rd_type      = 3'b000;
    rd_addr      = '0;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    ic_ret_data  = '0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    dc_ret_data  = '0;
    wr_req       = 1'b0;
    dc_wr_rdy    = 1'b0;
    wr_type      = dc_wr_type;
    wr_addr      = dc_wr_addr;
    wr_wstrb     = dc_wr_wstrb;
    wr_data      = dc_wr_data;

    case (r_state_q)
      R_IDLE: begin
        // grant_valid is only set in R_IDLE (elig is masked elsewhere).
        if (grant_valid) begin
          rd_req    = 1'b1;
          rd_type   = (grant_id == REQ_IC) ? ic_rd_type : dc_rd_type;
          rd_addr   = (grant_id == REQ_IC) ? ic_rd_addr : dc_rd_addr;
          ic_rd_rdy = (grant_id == REQ_IC) && rd_rdy;
          dc_rd_rdy = (grant_id == REQ_DC) && rd_rdy;
        end
        if (rd_accept) begin
          owner_d   = grant_id;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (owner_q == REQ_IC) begin
          ic_ret_valid = ret_valid;
          ic_ret_last  = ret_valid && ret_last;
          ic_ret_data  = ret_valid ? ret_data : '0;
        end else begin
          dc_ret_valid = ret_valid;
          dc_ret_last  = ret_valid && ret_last;
          dc_ret_data  = ret_valid ? ret_data : '0;
        end
        if (ret_valid && ret_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase

    case (w_state_q)
      W_IDLE: begin
        wr_req    = dc_wr_req;
        dc_wr_rdy = wr_rdy;
        if (dc_wr_req && wr_rdy) begin
          wr_line_d = dc_wr_addr[ADDR_W-1:LINE_OFF];
          w_state_d = W_BUSY;
        end
      end
      W_BUSY: begin
        if (wr_done) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    // Outputs are forced low while reset is asserted, without waiting for a clock.
    if (!resetn) begin
      rd_req       = 1'b0;
      rd_type      = 3'b000;
      rd_addr      = '0;
      ic_rd_rdy    = 1'b0;
      dc_rd_rdy    = 1'b0;
      ic_ret_valid = 1'b0;
      ic_ret_last  = 1'b0;
      ic_ret_data  = '0;
      dc_ret_valid = 1'b0;
      dc_ret_last  = 1'b0;
      dc_ret_data  = '0;
      wr_req       = 1'b0;
      dc_wr_rdy    = 1'b0;
      wr_type      = 3'b000;
      wr_addr      = '0;
      wr_wstrb     = '0;
      wr_data      = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      owner_q   <= REQ_IC;
      wr_line_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      owner_q   <= owner_d;
      wr_line_q <= wr_line_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb/tb_cache_axi_arbiter.sv - directed self-checking bench for cache_axi_arbiter
module tb_cache_axi_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ic_rd_req;
  logic [2:0]   ic_rd_type;
  logic [31:0]  ic_rd_addr;
  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0]  ic_ret_data;
  logic         dc_rd_req;
  logic [2:0]   dc_rd_type;
  logic [31:0]  dc_rd_addr;
  logic         dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0]  dc_ret_data;
  logic         dc_wr_req;
  logic [2:0]   dc_wr_type;
  logic [31:0]  dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         dc_wr_rdy;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy, wr_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_axi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
    .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    ic_rd_req = 0; ic_rd_type = 3'b100; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_type = 3'b100; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_type = 3'b100; dc_wr_addr = 0;
    dc_wr_wstrb = 4'hf; dc_wr_data = 128'h0;
    rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
    wr_rdy = 1; wr_done = 0;
    #1;
    chk("rst_rd_req", rd_req, 0);
    chk("rst_dc_wr_rdy", dc_wr_rdy, 0);
    chk("rst_wr_req", wr_req, 0);
    step(); step();
    resetn = 1'b1;
    #1;
    chk("post_rst_dc_wr_rdy", dc_wr_rdy, 1);
    chk("post_rst_rd_req", rd_req, 0);

    // Stray return beat in R_IDLE is dropped.
    ret_valid = 1; ret_last = 1; ret_data = 32'h55;
    #1;
    chk("idle_ret_ic", ic_ret_valid, 0);
    chk("idle_ret_dc", dc_ret_valid, 0);
    ret_valid = 0; ret_last = 0;

    // Round-robin tie: icache first.
    ic_rd_req = 1; ic_rd_addr = 32'h1000;
    dc_rd_req = 1; dc_rd_addr = 32'h2000;
    rd_rdy = 1;
    #1;
    chk("tie_rd_req", rd_req, 1);
    chk("tie_rd_addr", rd_addr, 32'h1000);
    chk("tie_rd_type", rd_type, 3'b100);
    chk("tie_ic_rdy", ic_rd_rdy, 1);
    chk("tie_dc_rdy", dc_rd_rdy, 0);
    step();
    ic_rd_req = 0;
    #1;
    chk("wait_rd_req", rd_req, 0);
    chk("wait_dc_rdy", dc_rd_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1; ret_last = (i == 3); ret_data = 32'h100 + i;
      #1;
      chk("ic_beat_valid", ic_ret_valid, 1);
      chk("ic_beat_data", ic_ret_data, 32'h100 + i);
      chk("ic_beat_last", ic_ret_last, (i == 3));
      chk("ic_beat_dc_valid", dc_ret_valid, 0);
      chk("ic_beat_no_grant", rd_req, 0);
      step();
    end
    ret_valid = 0; ret_last = 0;
    #1;
    chk("rr_second_addr", rd_addr, 32'h2000);
    chk("rr_second_dc_rdy", dc_rd_rdy, 1);
    chk("rr_second_ic_rdy", ic_rd_rdy, 0);
    step();
    dc_rd_req = 0;

    // Return steering to dcache.
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1; ret_last = (i == 3); ret_data = 32'hA + i;
      #1;
      chk("dc_beat_valid", dc_ret_valid, 1);
      chk("dc_beat_data", dc_ret_data, 32'hA + i);
      chk("dc_beat_last", dc_ret_last, (i == 3));
      chk("dc_beat_ic_valid", ic_ret_valid, 0);
      chk("dc_beat_ic_data", ic_ret_data, 0);
      step();
    end
    ret_valid = 0; ret_last = 0;

    // Back-pressure.
    rd_rdy = 0; ic_rd_req = 1; ic_rd_addr = 32'h5000; ic_rd_type = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rd_req", rd_req, 1);
      chk("bp_rd_addr", rd_addr, 32'h5000);
      chk("bp_ic_rdy", ic_rd_rdy, 0);
      step();
    end
    rd_rdy = 1;
    #1;
    chk("bp_accept", ic_rd_rdy, 1);
    chk("bp_type", rd_type, 3'b010);
    step();
    ic_rd_req = 0; ic_rd_type = 3'b100;
    ret_valid = 1; ret_last = 1; ret_data = 32'h77;
    #1;
    chk("bp_ret", ic_ret_valid, 1);
    step();
    ret_valid = 0; ret_last = 0;

    // RAW hazard and single outstanding write.
    dc_wr_req = 1; dc_wr_addr = 32'h3000; dc_wr_data = 128'hDEAD_BEEF;
    #1;
    chk("wr_req_pass", wr_req, 1);
    chk("wr_addr_pass", wr_addr, 32'h3000);
    chk("wr_data_pass", wr_data, 128'hDEAD_BEEF);
    chk("wr_rdy_idle", dc_wr_rdy, 1);
    step();
    dc_wr_req = 0;
    dc_rd_req = 1; dc_rd_addr = 32'h3008;
    #1;
    chk("raw_blocked", rd_req, 0);
    chk("raw_dc_rdy", dc_rd_rdy, 0);
    chk("busy_wr_rdy", dc_wr_rdy, 0);
    ic_rd_req = 1; ic_rd_addr = 32'h4000;
    #1;
    chk("raw_ic_proceeds", rd_addr, 32'h4000);
    chk("raw_ic_rdy", ic_rd_rdy, 1);
    chk("raw_dc_still_rdy", dc_rd_rdy, 0);
    step();
    ic_rd_req = 0;
    ret_valid = 1; ret_last = 1; ret_data = 32'h44;
    #1;
    chk("raw_ic_ret", ic_ret_valid, 1);
    step();
    ret_valid = 0; ret_last = 0;
    dc_wr_req = 1; dc_wr_addr = 32'h6000;
    #1;
    chk("raw_still_blocked", rd_req, 0);
    chk("wr2_rdy_busy", dc_wr_rdy, 0);
    chk("wr2_req_busy", wr_req, 0);
    step();
    chk("wr2_req_busy2", wr_req, 0);
    wr_done = 1;
    #1;
    chk("raw_release_req", rd_req, 1);
    chk("raw_release_addr", rd_addr, 32'h3008);
    chk("raw_release_rdy", dc_rd_rdy, 1);
    chk("wr_done_cycle_rdy", dc_wr_rdy, 0);
    step();
    wr_done = 0; dc_rd_req = 0;
    #1;
    chk("wr2_req_idle", wr_req, 1);
    chk("wr2_addr", wr_addr, 32'h6000);
    chk("wr2_rdy_idle", dc_wr_rdy, 1);
    step();
    dc_wr_req = 0;
    ret_valid = 1; ret_last = 1; ret_data = 32'h88;
    #1;
    chk("raw_dc_ret", dc_ret_valid, 1);
    chk("raw_dc_ret_data", dc_ret_data, 32'h88);
    step();
    ret_valid = 0; ret_last = 0;
    wr_done = 1;
    step();
    wr_done = 0;

    // Async reset mid-burst.
    ic_rd_req = 1; ic_rd_addr = 32'h7000;
    step();
    ic_rd_req = 0;
    ret_valid = 1; ret_last = 0; ret_data = 32'h1;
    step();
    ret_data = 32'h2;
    #1;
    chk("mid_beat2", ic_ret_valid, 1);
    resetn = 0;
    #1;
    chk("arst_ic_valid", ic_ret_valid, 0);
    chk("arst_ic_data", ic_ret_data, 0);
    chk("arst_wr_rdy", dc_wr_rdy, 0);
    ret_valid = 0;
    step();
    resetn = 1;
    ic_rd_req = 1; ic_rd_addr = 32'h8000;
    dc_rd_req = 1; dc_rd_addr = 32'h9000;
    #1;
    chk("arst_regrant_addr", rd_addr, 32'h8000);
    chk("arst_regrant_rdy", ic_rd_rdy, 1);
    step();
    ic_rd_req = 0; dc_rd_req = 0;
    ret_valid = 1; ret_last = 1;
    step();
    ret_valid = 0; ret_last = 0;

    // Same-cycle write acceptance and read to the same line: not hazarded.
    dc_wr_req = 1; dc_wr_addr = 32'hA000;
    dc_rd_req = 1; dc_rd_addr = 32'hA004;
    #1;
    chk("same_cycle_rd_req", rd_req, 1);
    chk("same_cycle_rd_addr", rd_addr, 32'hA004);
    chk("same_cycle_wr_req", wr_req, 1);
    step();
    dc_wr_req = 0; dc_rd_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
